// File: rtl/uart_pkg.sv
// Shared UART transmit-scheduler definitions: FSM states, baud-select codes and frame lengths.
// UART_TX_PARITY_EN adds the PARITY state and selects the 11-period frame length.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ALIGN  = 3'd1,
    ST_START  = 3'd2,
    ST_DATA   = 3'd3,
`ifdef UART_TX_PARITY_EN
    ST_PARITY = 3'd4,
`endif
    ST_STOP   = 3'd5
  } uart_state_e;

  localparam logic [2:0] BC_9600   = 3'b000;
  localparam logic [2:0] BC_19200  = 3'b001;
  localparam logic [2:0] BC_38400  = 3'b010;
  localparam logic [2:0] BC_57600  = 3'b011;
  localparam logic [2:0] BC_115200 = 3'b100;

  localparam int FRAME_TICKS_8N1 = 10;
  localparam int FRAME_TICKS_8E1 = 11;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_TICKS = FRAME_TICKS_8E1;
`else
  localparam int FRAME_TICKS = FRAME_TICKS_8N1;
`endif

endpackage

// File: rtl/uart_rr_arbiter.sv
// Combinational round-robin winner: first valid requester at or after ptr, wrapping modulo NUM_REQ.
module uart_rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         valid,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] win
);
  localparam int PW = $clog2(NUM_REQ);

  logic [PW:0] pos;
  logic        found;

  always_comb begin
    grant = '0;
    win   = '0;
    found = 1'b0;
    pos   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pos = {1'b0, ptr} + (PW+1)'(i);
      if (pos >= (PW+1)'(NUM_REQ)) pos = pos - (PW+1)'(NUM_REQ);
      if (!found && valid[pos[PW-1:0]]) begin
        found                 = 1'b1;
        grant[pos[PW-1:0]]    = 1'b1;
        win                   = pos[PW-1:0];
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin UART TX scheduler: arbitrates NUM_REQ byte sources onto one 8N1 line paced by baud_tick,
// and applies baud-select updates only between frames. Define UART_TX_PARITY_EN for 8E1 frames.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int         NUM_REQ  = 4,
  parameter logic [2:0] BC_RESET = BC_9600
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       baud_tick,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [2:0]                 bc_in,
  input  logic                       bc_load,
  output logic [2:0]                 bc_out,
  output logic                       tx,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id
);
  localparam int PW = $clog2(NUM_REQ);

  uart_state_e        state, state_n;
  logic [PW-1:0]      ptr, win;
  logic [NUM_REQ-1:0] grant;
  logic [7:0]         data_q, sel_byte;
  logic [2:0]         cnt, cnt_n;
  logic               tx_n, busy_n;
  logic               pend, cfg_now, can_grant, accept;
  logic [2:0]         pend_bc, cfg_bc;

  uart_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .valid (req_valid),
    .ptr   (ptr),
    .grant (grant),
    .win   (win)
  );

  // A load seen in IDLE is applied at once and costs that cycle's grant; otherwise it waits in pend_bc.
  assign cfg_now   = bc_load | pend;
  assign cfg_bc    = bc_load ? bc_in : pend_bc;
  assign can_grant = rst_n && (state == ST_IDLE) && !cfg_now;
  assign req_ready = can_grant ? grant : '0;
  assign accept    = can_grant && (|req_valid);

  always_comb begin
    sel_byte = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (grant[i]) sel_byte = req_data[8*i +: 8];
  end

  always_comb begin
    state_n = state;
    tx_n    = tx;
    busy_n  = busy;
    cnt_n   = cnt;
    case (state)
      ST_IDLE: if (accept) begin
        state_n = ST_ALIGN;
        busy_n  = 1'b1;
      end
      ST_ALIGN: if (baud_tick) begin
        state_n = ST_START;
        tx_n    = 1'b0;
      end
      ST_START: if (baud_tick) begin
        state_n = ST_DATA;
        tx_n    = data_q[0];
        cnt_n   = '0;
      end
      ST_DATA: if (baud_tick) begin
        cnt_n = cnt + 3'd1;
        if (cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
          state_n = ST_PARITY;
          tx_n    = ^data_q;
`else
          state_n = ST_STOP;
          tx_n    = 1'b1;
`endif
        end else begin
          tx_n = data_q[cnt + 3'd1];
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: if (baud_tick) begin
        state_n = ST_STOP;
        tx_n    = 1'b1;
      end
`endif
      ST_STOP: if (baud_tick) begin
        state_n = ST_IDLE;
        busy_n  = 1'b0;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      tx    <= 1'b1;
      busy  <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      tx    <= tx_n;
      busy  <= busy_n;
      cnt   <= cnt_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr      <= '0;
      grant_id <= '0;
      pend     <= 1'b0;
      pend_bc  <= BC_RESET;
      bc_out   <= BC_RESET;
    end else begin
      if (accept) begin
        grant_id <= win;
        ptr      <= (win == PW'(NUM_REQ-1)) ? '0 : win + 1'b1;
      end
      if (state == ST_IDLE && cfg_now) begin
        bc_out <= cfg_bc;
        pend   <= 1'b0;
      end else if (bc_load) begin
        pend    <= 1'b1;
        pend_bc <= bc_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) data_q <= sel_byte;
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: expected (requester, byte) frames are queued when stimulus is loaded and
// checked by a serial receiver on tx; follows UART_TX_PARITY_EN for the frame layout.
module tb_uart_tx_sched;
  localparam int N    = 4;
  localparam int MAXB = 64;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           baud_tick = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]   req_ready;
  logic [2:0]     bc_in = 3'b000;
  logic           bc_load = 1'b0;
  logic [2:0]     bc_out;
  logic           tx, busy;
  logic [1:0]     grant_id;

  uart_tx_sched #(.NUM_REQ(N), .BC_RESET(3'b000)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .baud_tick (baud_tick),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .bc_in     (bc_in),
    .bc_load   (bc_load),
    .bc_out    (bc_out),
    .tx        (tx),
    .busy      (busy),
    .grant_id  (grant_id)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Per-requester byte streams; rd advances on handshake, pn on planning.
  logic [7:0]  sbuf [N][MAXB];
  int          wr [N] = '{default: 0};
  int          rd [N] = '{default: 0};
  int          pn [N] = '{default: 0};
  int          mptr = 0;
  logic [10:0] exp_q [$];

  task automatic load(input int i, input logic [7:0] b);
    sbuf[i][wr[i]] = b;
    wr[i]++;
  endtask

  // Reference round-robin: each grant goes to the first non-empty stream at or after the pointer.
  task automatic plan();
    int w;
    bit found;
    do begin
      found = 1'b0;
      for (int k = 0; k < N && !found; k++) begin
        w = (mptr + k) % N;
        if (pn[w] < wr[w]) begin
          exp_q.push_back({w[2:0], sbuf[w][pn[w]]});
          pn[w]++;
          mptr  = (w + 1) % N;
          found = 1'b1;
        end
      end
    end while (found);
  endtask

  function automatic bit all_done();
    for (int i = 0; i < N; i++) if (rd[i] != wr[i]) return 1'b0;
    return 1'b1;
  endfunction

  // Requester driver
  int           rdy0_cycles = 0;
  logic [N-1:0] acc = '0;
  initial begin
    forever begin
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) if (acc[i]) rd[i]++;
      for (int i = 0; i < N; i++) begin
        req_valid[i] = (rd[i] < wr[i]);
        if (rd[i] < wr[i]) req_data[8*i +: 8] = sbuf[i][rd[i]];
        else               req_data[8*i +: 8] = 8'($urandom);
      end
      @(negedge clk);
      acc = req_valid & req_ready;
      if (req_ready[0]) rdy0_cycles++;
      if (acc != '0) check("ready_onehot", {31'b0, $onehot(req_ready)}, 1);
    end
  end

  // Baud tick source: fixed period or random spacing
  int tick_per  = 10;
  bit tick_rand = 1'b0;
  initial begin
    int cd;
    cd = 0;
    forever begin
      @(posedge clk); #1;
      if (cd == 0) begin
        baud_tick = 1'b1;
        cd = tick_rand ? int'($urandom_range(0, 6)) : tick_per - 1;
      end else begin
        baud_tick = 1'b0;
        cd--;
      end
    end
  end

  // Serial receiver / scoreboard monitor: one sample per tick period
`ifdef UART_TX_PARITY_EN
  localparam int NPAR = 1;
`else
  localparam int NPAR = 0;
`endif
  int         rpos = 0;
  logic [7:0] rbyte = '0;
  logic [1:0] rid = '0;
  logic       last_tick = 1'b0;
  logic       last_tx = 1'b1;
  initial begin
    logic [10:0] e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        rpos = 0;
      end else begin
        if (tx !== last_tx) check("tx_moves_on_tick", {31'b0, last_tick}, 1);
        if (last_tick) begin
          if (rpos == 0) begin
            if (tx == 1'b0) begin
              rid = grant_id;
              check("busy_in_frame", {31'b0, busy}, 1);
              rpos = 1;
            end
          end else if (rpos <= 8) begin
            rbyte[rpos-1] = tx;
            rpos++;
`ifdef UART_TX_PARITY_EN
          end else if (rpos == 9) begin
            check("parity_bit", {31'b0, tx}, {31'b0, ^rbyte});
            rpos++;
`endif
          end else if (rpos == 9 + NPAR) begin
            check("stop_bit", {31'b0, tx}, 1);
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_frame: got id %0d byte %0h, expected no frame", rid, rbyte);
            end else begin
              e = exp_q.pop_front();
              check("frame_id", {30'b0, rid}, {29'b0, e[10:8]});
              check("frame_byte", {24'b0, rbyte}, {24'b0, e[7:0]});
              check("grant_id_held", {30'b0, grant_id}, {30'b0, rid});
            end
            rpos++;
          end else begin
            check("busy_after_stop", {31'b0, busy}, 0);
            check("idle_after_stop", {31'b0, tx}, 1);
            rpos = 0;
          end
        end
      end
      last_tick = baud_tick;
      last_tx   = tx;
    end
  end

  task automatic wait_drain(input int maxc, input string name);
    int n;
    n = 0;
    while (!(all_done() && exp_q.size() == 0 && !busy && rpos == 0) && n < maxc) begin
      @(negedge clk);
      n++;
    end
    if (n >= maxc) begin
      checks++;
      errors++;
      $display("FAIL %s: timeout after %0d cycles, got %0d frames outstanding, expected 0", name, maxc, exp_q.size());
    end
  endtask

  task automatic wait_rpos(input int k, input string name);
    int n;
    n = 0;
    while (rpos < k && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (rpos < k) begin
      checks++;
      errors++;
      $display("FAIL %s: receiver at bit %0d, expected at least %0d", name, rpos, k);
    end
  endtask

  task automatic pulse_load(input logic [2:0] code);
    @(posedge clk); #1;
    bc_in   = code;
    bc_load = 1'b1;
    @(posedge clk); #1;
    bc_load = 1'b0;
  endtask

  task automatic hold_bc_while_busy(input logic [2:0] code, input string name);
    int n;
    n = 0;
    while (busy && n < 2000) begin
      check(name, {29'b0, bc_out}, {29'b0, code});
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    int total;
    int c;

    repeat (3) @(negedge clk);
    check("rst_tx", {31'b0, tx}, 1);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_grant_id", {30'b0, grant_id}, 0);
    check("rst_bc_out", {29'b0, bc_out}, 0);
    check("rst_ready", {28'b0, req_ready}, 0);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // All four streams busy from pointer 0: grants 0,1,2,3,0
    tick_per = 5;
    load(0, 8'h3C); load(0, 8'hC3); load(1, 8'h5A); load(2, 8'h81); load(3, 8'h7E);
    plan();
    wait_drain(3000, "rr_all_valid");

    // Single byte A5 from requester 0, tick every 10 cycles
    tick_per    = 10;
    rdy0_cycles = 0;
    load(0, 8'hA5);
    plan();
    wait_drain(1000, "single_byte");
    check("ready0_one_cycle", rdy0_cycles, 1);

    // Wrap: move pointer to 3, then valid=0101 must grant 0 before 2
    tick_per = 4;
    load(2, 8'h11);
    plan();
    wait_drain(1000, "wrap_setup");
    load(0, 8'h22); load(2, 8'h44);
    plan();
    wait_drain(1000, "wrap");

    // Random traffic with random tick spacing
    tick_rand = 1'b1;
    repeat (4) begin
      total = 0;
      for (int i = 0; i < N; i++) begin
        c = int'($urandom_range(0, 3));
        for (int j = 0; j < c; j++) load(i, 8'($urandom));
        total += c;
      end
      if (total == 0) load(int'($urandom_range(0, N-1)), 8'($urandom));
      plan();
      wait_drain(4000, "random_batch");
    end
    tick_rand = 1'b0;

    // Config deferral: load 100 mid-DATA, requester 1 waiting behind it
    tick_per = 6;
    load(0, 8'h96);
    plan();
    wait_rpos(3, "cfg_mid_data");
    pulse_load(3'b100);
    @(negedge clk);
    load(1, 8'h69);
    plan();
    hold_bc_while_busy(3'b000, "bc_held_in_frame");
    check("bc_defer_old", {29'b0, bc_out}, 0);
    check("ready_blocked_by_cfg", {28'b0, req_ready}, 0);
    @(negedge clk);
    check("bc_defer_new", {29'b0, bc_out}, 3'b100);
    check("ready_after_cfg", {28'b0, req_ready}, 4'b0010);
    wait_drain(2000, "cfg_defer");

    // Two loads in one frame: only the last applies
    load(2, 8'hF0);
    plan();
    wait_rpos(2, "two_loads_frame");
    pulse_load(3'b001);
    repeat (2) @(posedge clk);
    pulse_load(3'b011);
    @(negedge clk);
    hold_bc_while_busy(3'b100, "bc_held_two_loads");
    check("bc_two_loads_old", {29'b0, bc_out}, 3'b100);
    @(negedge clk);
    check("bc_last_wins", {29'b0, bc_out}, 3'b011);
    wait_drain(2000, "two_loads");

    // bc_load and req_valid together in IDLE: config first, grant one cycle later
    load(1, 8'h0F);
    plan();
    @(posedge clk); #1;
    bc_in   = 3'b010;
    bc_load = 1'b1;
    @(negedge clk);
    check("sim_ready_blocked", {28'b0, req_ready}, 0);
    check("sim_bc_old", {29'b0, bc_out}, 3'b011);
    @(posedge clk); #1;
    bc_load = 1'b0;
    @(negedge clk);
    check("sim_bc_new", {29'b0, bc_out}, 3'b010);
    check("sim_ready1", {28'b0, req_ready}, 4'b0010);
    wait_drain(2000, "simultaneous");

    // Reset during data bit 4: frame dropped, outputs back to reset values at once
    load(2, 8'hE7);
    pn[2] = wr[2];
    wait_rpos(6, "reset_mid_data");
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_tx", {31'b0, tx}, 1);
    check("mid_rst_busy", {31'b0, busy}, 0);
    check("mid_rst_bc_out", {29'b0, bc_out}, 0);
    check("mid_rst_grant_id", {30'b0, grant_id}, 0);
    @(negedge clk); #2;
    rst_n = 1'b1;
    mptr  = 0;
    @(negedge clk);
    load(1, 8'h12); load(2, 8'h34); load(3, 8'h56);
    plan();
    wait_drain(3000, "after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog: simulation still running at t=%0t, expected completion", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
- Sequencer and arbiter placed in front of the baud-rate generator.
- Shares one serial TX line between NUM_REQ byte requesters using a round-robin policy.
- Shifts each granted byte out as an 8N1 frame, one bit per baud tick (the generator's `ena` pulse).
- Owns the generator's 3-bit baud-select code and changes it only between frames, so no frame is ever sent at mixed rates.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- BC_RESET, 3'b000, baud-select code after reset (000 = 9600).

Ports:
- clk  in  1  system clock, 50 MHz.
- rst_n  in  1  asynchronous active-low reset.
- baud_tick  in  1  one-cycle pulse per bit period, from the baud generator `ena`.
- req_valid  in  NUM_REQ  per-requester byte valid.
- req_data  in  8*NUM_REQ  byte for requester i at [8i+7:8i].
- req_ready  out  NUM_REQ  one-hot accept; a transfer occurs when valid & ready.
- bc_in  in  3  new baud-select code.
- bc_load  in  1  one-cycle pulse; captures bc_in as a pending update.
- bc_out  out  3  baud-select code driven to the baud generator.
- tx  out  1  serial line, idle high.
- busy  out  1  high from accept until the end of the stop bit.
- grant_id  out  $clog2(NUM_REQ)  index of the requester being serialised.

Behaviour:
- Reset (asynchronous, rst_n=0) forces:
  - state=IDLE, tx=1, busy=0, grant_id=0, bc_out=BC_RESET.
  - pending flag cleared; RR pointer=0; req_ready=0.
- States: IDLE, ALIGN, START, DATA, STOP.
- req_ready is combinational: one-hot winner when state==IDLE, no pending config, and |req_valid.
  - Winner is the first valid index at or after the pointer, wrapping modulo NUM_REQ.
- Accept (valid & ready, cycle A):
  - Latch the byte and grant_id.
  - busy=1; pointer=winner+1 (mod NUM_REQ); go to ALIGN.
- ALIGN: wait for baud_tick. On that tick, tx=0 and go to START.
- START: on the next tick, tx=data[0], bit counter=0, go to DATA.
- DATA: on each tick, counter+1.
  - At counter 7, tx=1 and go to STOP.
  - Otherwise tx=data[counter+1].
  - Bits go out LSB first.
- STOP: on the next tick, go to IDLE and set busy=0. tx stays 1.
- Timing: every tx change occurs only in a cycle with baud_tick=1. A frame is exactly 10 tick periods, measured from the ALIGN-exit tick.
- A baud_tick in the accept cycle itself is ignored; alignment starts on the following tick.
- Config path:
  - bc_load captures bc_in into the pending register in any state. A later load overwrites an earlier pending one (last wins).
  - In IDLE with pending set: bc_out<=pending, pending cleared. This takes one cycle, and no grant is issued that cycle.
  - bc_load together with valid in IDLE: config has priority. The grant is delayed exactly one cycle.
- req_valid deasserted after accept has no effect on the frame in flight.
- Back-to-back: a new grant is possible in the cycle after the STOP tick. There is no idle gap beyond alignment to the next tick.
- rst_n asserted mid-frame: tx returns to 1 immediately (asynchronous); the partial frame is dropped.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: a PARITY state sits between DATA and STOP.
  - On the tick leaving DATA, tx = even parity (XOR of the 8 data bits).
  - STOP follows on the next tick. Frame = 11 tick periods.
- Undefined: 8N1 only, 10 tick periods; the PARITY state and its logic are absent.

Decomposition:
- Shared package uart_pkg:
  - State enum for this block.
  - Baud-select code constants BC_9600=000, BC_19200=001, BC_38400=010, BC_57600=011, BC_115200=100.
  - Frame length constants.
- Sub-module uart_rr_arbiter: combinational one-hot winner selection from req_valid and pointer. The pointer register lives in the parent.

Test Plan:
- Single byte: req_valid=0001, req_data[7:0]=8'hA5, tick every 10 cycles → ready[0] for 1 cycle. Then tx = 0,1,0,1,0,0,1,0,1,1 across ten successive tick periods; busy falls on the STOP tick.
- Round-robin: all four requesters valid continuously → grant order 0,1,2,3,0; each grant_id held for a full frame.
- Wrap: pointer=3 with valid=0101 → grant 0, then 2.
- Config deferral: bc_load with bc_in=100 mid-DATA → bc_out stays 000 until the cycle after the STOP tick, then 100. The pending requester is granted one cycle later.
- Simultaneous: bc_load=1 and req_valid=0010 in IDLE → bc_out updates in cycle N, ready[1] asserts in cycle N+1. Also: two loads (001 then 011) during a frame → bc_out=011 only.
- Reset mid-DATA: drop rst_n during bit 4 → tx=1, busy=0, bc_out=BC_RESET within the same cycle. After release, next grant starts from requester 0.
